fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the write port of one synchronous FIFO among NUM_REQ requesters. Each requester presents words on a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and steers that requester's data onto the FIFO write port. It stalls on FIFO full and never writes into a full FIFO. It sits directly in front of the FIFO's data_in/wr_en/full pins.

---
 rtl/fifo_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one synchronous FIFO write port among NUM_REQ
// valid/ready requesters. Grants one requester at a time for up to
// MAX_BURST words and stalls on fifo full.
// Optional build macro: FIFO_WR_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins). When it is undefined, the winner is picked
// round-robin, starting after the last granted requester.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_fifo_data_in,
  output logic                          o_fifo_wr_en,
  input  logic                          i_fifo_full,
  output logic [ID_W-1:0]               o_grant_id,
  output logic                          o_busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // burst_cnt value seen on the final word of a grant
  localparam logic [7:0] LP_LAST_CNT = 8'(MAX_BURST - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       w_grant_nxt;
  logic [ID_W-1:0]       r_last_grant;
  logic [ID_W-1:0]       w_last_nxt;
  logic [7:0]            r_burst_cnt;
  logic [7:0]            w_cnt_nxt;
  logic [ID_W-1:0]       w_winner;
  logic                  w_xfer;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

  // Round-robin search: first valid requester after 'last', wrapping.
  // Scanning from the farthest candidate down lets the nearest one win.
  function automatic logic [ID_W-1:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  // Fixed priority search: lowest valid index wins.
  function automatic logic [ID_W-1:0] f_fixed_pick(input logic [NUM_REQ-1:0] valid);
    logic [ID_W-1:0] pick;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[k]) pick = ID_W'(k);
    end
    return pick;
  endfunction

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
  assign w_winner = f_fixed_pick(i_req_valid);
`else
  assign w_winner = f_rr_pick(i_req_valid, r_last_grant);
`endif

  // Split the packed requester data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_words[i] = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state, grant bookkeeping and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_burst_cnt;
    w_req_ready = '0;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_req_valid) begin
          w_grant_nxt = w_winner;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = BURST;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BURST: begin
        w_req_ready[r_grant_id] = ~i_fifo_full;
        w_xfer = i_req_valid[r_grant_id] & ~i_fifo_full;
        if (w_xfer) begin
          w_cnt_nxt = r_burst_cnt + 8'd1;
          if (r_burst_cnt == LP_LAST_CNT) begin
            w_last_nxt  = r_grant_id;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = BURST;
          end
        end else if (!i_req_valid[r_grant_id]) begin
          // requester withdrew: end the grant, nothing is lost
          w_last_nxt  = r_grant_id;
          w_state_nxt = IDLE;
        end else begin
          // fifo full with data pending: hold everything
          w_state_nxt = BURST;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Write path: steer the granted word only on a real transfer, else zero.
  always_comb begin
    if (w_xfer) begin
      o_fifo_data_in = w_words[r_grant_id];
    end else begin
      o_fifo_data_in = '0;
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_fifo_wr_en = w_xfer;
  assign o_grant_id   = r_grant_id;
  assign o_busy       = (r_state == BURST);

  // State and grant registers; reset makes requester 0 the first winner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_burst_cnt  <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the grant/burst rules.
// Honours FIFO_WR_ARB_FIXED_PRIO_EN for the expected winner order.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic          fifo_full = 1'b0;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_wr_en;
  logic [1:0]    grant_id;
  logic          busy;

  // second instance with single-word bursts, sharing the inputs
  logic [N-1:0]  b1_ready;
  logic [DW-1:0] b1_data;
  logic          b1_wr;
  logic [1:0]    b1_gid;
  logic          b1_busy;

  int checks = 0;
  int errors = 0;

  // behavioural model: owner = granted requester or -1 when idle
  int m_owner, m_cnt, m_last, m_gid;
  logic [N-1:0]  e_ready;
  logic          e_wr;
  logic [DW-1:0] e_data;
  logic [1:0]    e_gid;
  logic          e_busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_fifo_data_in(fifo_data_in), .o_fifo_wr_en(fifo_wr_en),
    .i_fifo_full(fifo_full), .o_grant_id(grant_id), .o_busy(busy));

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1), .ID_W(2)) dut_b1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(b1_ready), .o_fifo_data_in(b1_data), .o_fifo_wr_en(b1_wr),
    .i_fifo_full(fifo_full), .o_grant_id(b1_gid), .o_busy(b1_busy));

  always #5 clk = ~clk;

  function automatic int pick_winner(input logic [N-1:0] v, input int last);
    int w;
    w = -1;
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (w < 0 && v[i]) w = i;
`else
    for (int k = 1; k <= N; k++) if (w < 0 && v[(last + k) % N]) w = (last + k) % N;
`endif
    return w;
  endfunction

  function automatic int exp_grant(input int k, input int n);
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    return 0;
`else
    return k % n;
`endif
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = N - 1; m_gid = 0;
  endtask

  task automatic model_eval();
    e_ready = '0; e_wr = 1'b0; e_data = '0;
    e_busy = (m_owner >= 0);
    e_gid = 2'(m_gid);
    if (m_owner >= 0) begin
      if (!fifo_full) e_ready[m_owner] = 1'b1;
      e_wr = req_valid[m_owner] && !fifo_full;
      if (e_wr) e_data = req_data[m_owner*DW +: DW];
    end
  endtask

  task automatic model_step();
    model_eval();
    if (m_owner < 0) begin
      if (req_valid != '0) begin
        m_owner = pick_winner(req_valid, m_last);
        m_gid = m_owner; m_cnt = 0;
      end
    end else if (e_wr) begin
      m_cnt++;
      if (m_cnt == MB) begin m_last = m_owner; m_owner = -1; end
    end else if (!req_valid[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end
  endtask

  // advance one clock; inputs may be changed right after return
  task automatic adv();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b exp 0", fifo_wr_en); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %0h exp 0", req_ready); end
    checks++; if (fifo_data_in !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 0", fifo_data_in); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d exp 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    adv();
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_data[2*DW +: DW] = 8'hA1;
    @(negedge clk);
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_idle_wr got %0b exp 0", fifo_wr_en); end
    adv();
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr%0d got %0b exp 1", w, fifo_wr_en); end
      checks++; if (fifo_data_in !== 8'(8'hA1 + w)) begin errors++; $display("FAIL single_data%0d got %0h exp %0h", w, fifo_data_in, 8'(8'hA1 + w)); end
      checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid got %0d exp 2", grant_id); end
      adv();
      req_data[2*DW +: DW] = 8'(8'hA2 + w);
    end
    req_valid = '0;
    @(negedge clk);
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_drop_wr got %0b exp 0", fifo_wr_en); end
    adv();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after got %0b exp 0", busy); end
    adv();
  endtask

  task automatic test_all_valid();
    do_reset();
    req_valid = 4'b1111; req_data = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++; if (fifo_wr_en !== (c % 5 != 0)) begin errors++; $display("FAIL rr_wr c%0d got %0b exp %0b", c, fifo_wr_en, (c % 5 != 0)); end
      if (c % 5 != 0) begin
        checks++; if (grant_id !== 2'(exp_grant(c / 5, N))) begin errors++; $display("FAIL rr_gid c%0d got %0d exp %0d", c, grant_id, exp_grant(c / 5, N)); end
        checks++; if (fifo_data_in !== 8'(8'h40 + exp_grant(c / 5, N))) begin errors++; $display("FAIL rr_data c%0d got %0h exp %0h", c, fifo_data_in, 8'(8'h40 + exp_grant(c / 5, N))); end
      end
      adv();
    end
    req_valid = '0;
    adv(); adv();
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0001; req_data[0 +: DW] = 8'h31;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got %0b exp 0", busy); end
    adv();
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      checks++; if (fifo_data_in !== 8'(8'h31 + w) || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL stall_pre%0d got %0h/%0b exp %0h/1", w, fifo_data_in, fifo_wr_en, 8'(8'h31 + w)); end
      adv();
      req_data[0 +: DW] = 8'(8'h32 + w);
    end
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr s%0d got %0b exp 0", s, fifo_wr_en); end
      checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL stall_ready s%0d got %0h/%0b exp 0/1", s, req_ready, busy); end
      adv();
    end
    fifo_full = 1'b0;
    for (int w = 2; w < 4; w++) begin
      @(negedge clk);
      checks++; if (fifo_data_in !== 8'(8'h31 + w) || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL stall_post%0d got %0h/%0b exp %0h/1", w, fifo_data_in, fifo_wr_en, 8'(8'h31 + w)); end
      adv();
      req_data[0 +: DW] = 8'(8'h32 + w);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL stall_end got %0b/%0b/%0h exp 0/0/0", busy, fifo_wr_en, req_ready); end
    req_valid = '0;
    adv();
  endtask

  task automatic test_drop();
    do_reset();
    req_valid = 4'b1010; req_data[1*DW +: DW] = 8'h51; req_data[3*DW +: DW] = 8'h71;
    adv();
    @(negedge clk);
    checks++; if (grant_id !== 2'd1 || fifo_data_in !== 8'h51 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL drop_first got %0d/%0h/%0b exp 1/51/1", grant_id, fifo_data_in, fifo_wr_en); end
    adv();
    req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL drop_nowrite got %0b exp 0", fifo_wr_en); end
    adv();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got %0b exp 0", busy); end
    adv();
    @(negedge clk);
    checks++; if (grant_id !== 2'd3 || fifo_data_in !== 8'h71 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL drop_next got %0d/%0h/%0b exp 3/71/1", grant_id, fifo_data_in, fifo_wr_en); end
    req_valid = '0;
    adv(); adv();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100; req_data = {8'h0, 8'h82, 8'h0, 8'h90};
    adv(); adv();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (fifo_wr_en !== 1'b0 || fifo_data_in !== 8'h00 || req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_out got %0b/%0h/%0h exp 0/0/0", fifo_wr_en, fifo_data_in, req_ready); end
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0b/%0d exp 0/0", busy, grant_id); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    req_valid = 4'b0101;
    adv();
    @(negedge clk);
    checks++; if (grant_id !== 2'd0 || fifo_wr_en !== 1'b1 || fifo_data_in !== 8'h90) begin errors++; $display("FAIL rstmid_first got %0d/%0b/%0h exp 0/1/90", grant_id, fifo_wr_en, fifo_data_in); end
    req_valid = '0;
    adv(); adv();
  endtask

  task automatic test_burst1();
    do_reset();
    req_valid = 4'b0011; req_data = {8'h0, 8'h0, 8'h61, 8'h60};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (b1_wr !== (c % 2 == 1)) begin errors++; $display("FAIL b1_wr c%0d got %0b exp %0b", c, b1_wr, (c % 2 == 1)); end
      if (c % 2 == 1) begin
        checks++; if (b1_gid !== 2'(exp_grant(c / 2, 2)) || b1_data !== 8'(8'h60 + exp_grant(c / 2, 2))) begin errors++; $display("FAIL b1_gid c%0d got %0d/%0h exp %0d", c, b1_gid, b1_data, exp_grant(c / 2, 2)); end
      end
      adv();
    end
    req_valid = '0;
    adv(); adv(); adv();
  endtask

  task automatic test_random();
    int writes;
    writes = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom_range(0, 15));
      fifo_full = ($urandom_range(0, 3) == 0);
      req_data = 32'($urandom);
      @(negedge clk);
      model_eval();
      checks++; if (fifo_wr_en !== e_wr || fifo_data_in !== e_data) begin errors++; $display("FAIL rnd_write c%0d got %0b/%0h exp %0b/%0h", c, fifo_wr_en, fifo_data_in, e_wr, e_data); end
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got %0h exp %0h", c, req_ready, e_ready); end
      checks++; if (grant_id !== e_gid || busy !== e_busy) begin errors++; $display("FAIL rnd_grant c%0d got %0d/%0b exp %0d/%0b", c, grant_id, busy, e_gid, e_busy); end
      if (e_wr) writes++;
      adv();
    end
    checks++; if (writes < 40) begin errors++; $display("FAIL rnd_activity got %0d writes exp >= 40", writes); end
    req_valid = '0; fifo_full = 1'b0;
    adv();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_valid();
    test_full_stall();
    test_drop();
    test_reset_mid();
    test_burst1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
